i2c_reg_ctrl: RTL
=================

Name: i2c_reg_ctrl

Overview:
- Register-access sequencer in front of the I2C bit-level shifter in the camera_init path.
- Takes one register write or read request: device ID, 8/16-bit register address, 8-bit data.
- Issues the ordered Cmd/Go/Tx_DATA byte steps to the shifter and waits for each Trans_Done.
- Collects slave ACKs and returns read data plus status to the camera init table walker.

Parameters:
- TIMEOUT_CYC, 100_000: max Clk cycles to wait for Trans_Done on one byte step before aborting.
- CNT_W, 17: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- Clk  in  1  system clock, shared with the bit shifter
- Rst  in  1  synchronous, active-high reset
- Wr_Req  in  1  single-cycle request: register write
- Rd_Req  in  1  single-cycle request: register read
- Dev_Id  in  8  7-bit address in [7:1]; bit 0 ignored and forced per phase
- Addr_Mode  in  1  0 = 8-bit register address, 1 = 16-bit
- Reg_Addr  in  16  register address; [15:8] unused when Addr_Mode=0
- Wr_Data  in  8  write data
- Rd_Data  out  8  read data, valid with RW_Done of a read
- RW_Done  out  1  one-cycle completion pulse
- Ack_Err  out  1  any write-phase byte NACKed in the last transaction
- Timeout  out  1  last transaction aborted by watchdog
- Busy  out  1  transaction in progress
- Cmd  out  6  to shifter command bus
- Go  out  1  to shifter start pulse
- Tx_DATA  out  8  to shifter byte to send
- Rx_DATA  in  8  from shifter received byte
- Trans_Done  in  1  from shifter step-complete pulse
- ack_i  in  1  from shifter ack_o (0 = ACK)

Behaviour:
- Reset values: Rd_Data=0, RW_Done=0, Ack_Err=0, Timeout=0, Busy=0, Cmd=0, Go=0, Tx_DATA=0. FSM goes to IDLE and step=0.
- Reset mid-transaction returns to IDLE immediately. No stop is generated; the shifter shares the same reset.
- Request acceptance:
  - A request is accepted only in IDLE.
  - Wr_Req and Rd_Req together: write wins, read dropped.
  - Requests while Busy are ignored, not queued.
  - On acceptance, all inputs are latched, Ack_Err and Timeout are cleared, and Busy=1 from the next cycle.
- Write sequence (steps; the step with addr_hi is skipped when Addr_Mode=0):
  - S0 Cmd=STA|WR (6'b000011), Tx={Dev_Id[7:1],0}
  - S1 WR, Tx=Reg_Addr[15:8]
  - S2 WR, Tx=Reg_Addr[7:0]
  - S3 WR|STO (6'b001001), Tx=Wr_Data
- Read sequence (SCCB style, stop then fresh start):
  - S0 and S1 as for write.
  - S2 WR|STO, Tx=Reg_Addr[7:0]
  - S3 STA|WR, Tx={Dev_Id[7:1],1}
  - S4 RD|NACK|STO (6'b101100)
- FSM states and transitions:
  - IDLE → ISSUE on accept.
  - ISSUE (1 cycle): Go=1 with Cmd/Tx_DATA for the current step; → WAIT.
  - WAIT: Go=0; Cmd/Tx_DATA held stable until Trans_Done.
    - On Trans_Done → NEXT.
    - On watchdog expiry → FINISH with Timeout=1.
  - NEXT (1 cycle): evaluate the step, then go to ISSUE for the next step, or FINISH after the last step.
  - FINISH: RW_Done=1 for one cycle, Busy=0 in the same cycle; → IDLE.
- ACK and data capture:
  - In the Trans_Done cycle of any write-type step, ack_i=1 sets Ack_Err (sticky).
  - The sequence still runs to the end, so the STO on the final step always releases the bus.
  - On the RD step, ack_i is not checked; Rx_DATA is latched into Rd_Data in the Trans_Done cycle.
- Watchdog:
  - Counts Clk cycles in WAIT and clears in ISSUE.
  - Count reaching TIMEOUT_CYC-1 without Trans_Done aborts; Rd_Data is unchanged on abort.
- Output retention: Rd_Data, Ack_Err and Timeout hold until the next accepted request.
- Trans_Done outside WAIT is ignored.
- Go is never asserted in two consecutive cycles, and never while the shifter is mid-step.

Decomposition:
- Shared package i2c_pkg:
  - Cmd bit constants WR=6'b000001, STA=6'b000010, RD=6'b000100, STO=6'b001000, ACK=6'b010000, NACK=6'b100000.
  - FSM state encoding.
  - Step-index localparams.
- Sub-module i2c_step_rom: combinational map from {is_read, Addr_Mode, step} to {Cmd, tx_sel, last}. Keeps the sequencer FSM free of per-step case logic.

Test Plan:
- Write, 16-bit address: Dev_Id=0x78, Reg_Addr=0x3008, Wr_Data=0x82, slave always ACKs.
  - Go pulses exactly 4 times with Cmd 03/01/01/09 and Tx 78/30/08/82.
  - RW_Done pulses once, Ack_Err=0, Busy low afterwards.
- Read, 8-bit address: Dev_Id=0x42, Reg_Addr=0x0A, slave returns 0x56.
  - Go pulses 4 times (16-bit step skipped) with Cmd 03/09/03/2C and Tx 42/0A/43/xx.
  - Rd_Data=0x56 on RW_Done.
- NACK on the address-high byte during a write: Ack_Err=1, all 4 steps still issued, the final step carries STO, RW_Done pulses once.
- Trans_Done withheld with TIMEOUT_CYC=50: Timeout=1 with RW_Done exactly 50 cycles after Go, Rd_Data unchanged, next request accepted normally.
- Edge cases, three cases:
  - Wr_Req and Rd_Req in the same cycle: a write sequence runs.
  - Wr_Req pulsed while Busy: ignored, only one RW_Done.
  - Rst asserted in WAIT: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access sequencer:
// shifter command bits, FSM states, step indices and the step-table entry.
package i2c_pkg;

  // Shifter command bits (OR together to form a Cmd word)
  localparam logic [5:0] WR   = 6'b000001;
  localparam logic [5:0] STA  = 6'b000010;
  localparam logic [5:0] RD   = 6'b000100;
  localparam logic [5:0] STO  = 6'b001000;
  localparam logic [5:0] ACK  = 6'b010000;
  localparam logic [5:0] NACK = 6'b100000;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_t;

  // Step indices. Step 3 is the data byte for a write and the
  // repeated-start device byte for a read.
  localparam logic [2:0] STEP_DEV     = 3'd0;
  localparam logic [2:0] STEP_ADDR_HI = 3'd1;
  localparam logic [2:0] STEP_ADDR_LO = 3'd2;
  localparam logic [2:0] STEP_DATA    = 3'd3;
  localparam logic [2:0] STEP_RD      = 3'd4;

  // Which byte goes onto Tx_DATA for a step
  typedef enum logic [2:0] {
    TX_DEV_W,
    TX_ADDR_HI,
    TX_ADDR_LO,
    TX_WDATA,
    TX_DEV_R,
    TX_NONE
  } tx_sel_t;

  // One row of the step table
  typedef struct packed {
    logic [5:0] cmd;
    tx_sel_t    tx_sel;
    logic       last;
    logic [2:0] next;
  } step_t;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Bundle of the request/response bus (toward the init table walker) and the
// shifter bus. The sequencer uses the slave modport; its environment the master.
interface i2c_reg_ctrl_if;
  // request / response side
  logic        Wr_Req;
  logic        Rd_Req;
  logic [7:0]  Dev_Id;
  logic        Addr_Mode;
  logic [15:0] Reg_Addr;
  logic [7:0]  Wr_Data;
  logic [7:0]  Rd_Data;
  logic        RW_Done;
  logic        Ack_Err;
  logic        Timeout;
  logic        Busy;
  // shifter side
  logic [5:0]  Cmd;
  logic        Go;
  logic [7:0]  Tx_DATA;
  logic [7:0]  Rx_DATA;
  logic        Trans_Done;
  logic        ack_i;

  modport slave (
    input  Wr_Req, Rd_Req, Dev_Id, Addr_Mode, Reg_Addr, Wr_Data,
    input  Rx_DATA, Trans_Done, ack_i,
    output Rd_Data, RW_Done, Ack_Err, Timeout, Busy,
    output Cmd, Go, Tx_DATA
  );

  modport master (
    output Wr_Req, Rd_Req, Dev_Id, Addr_Mode, Reg_Addr, Wr_Data,
    output Rx_DATA, Trans_Done, ack_i,
    input  Rd_Data, RW_Done, Ack_Err, Timeout, Busy,
    input  Cmd, Go, Tx_DATA
  );
endinterface

// File: rtl/i2c_step_rom.sv
// Step table: maps {is_read, addr_mode, step} to the shifter command, the
// byte source, whether this is the final step and which step follows.
module i2c_step_rom
  import i2c_pkg::*;
(
  input  logic       is_read,
  input  logic       addr_mode,
  input  logic [2:0] step,
  output step_t      entry
);

  // Pure lookup; unused combinations fall back to a harmless terminal entry
  always_comb begin
    entry.cmd    = '0;
    entry.tx_sel = TX_NONE;
    entry.last   = 1'b1;
    entry.next   = STEP_DEV;
    case (step)
      STEP_DEV: begin
        entry.cmd    = STA | WR;
        entry.tx_sel = TX_DEV_W;
        entry.last   = 1'b0;
        // 8-bit addressing skips the high address byte
        entry.next   = addr_mode ? STEP_ADDR_HI : STEP_ADDR_LO;
      end
      STEP_ADDR_HI: begin
        entry.cmd    = WR;
        entry.tx_sel = TX_ADDR_HI;
        entry.last   = 1'b0;
        entry.next   = STEP_ADDR_LO;
      end
      STEP_ADDR_LO: begin
        // SCCB-style read closes the address phase with a stop
        entry.cmd    = is_read ? (WR | STO) : WR;
        entry.tx_sel = TX_ADDR_LO;
        entry.last   = 1'b0;
        entry.next   = STEP_DATA;
      end
      STEP_DATA: begin
        if (is_read) begin
          entry.cmd    = STA | WR;
          entry.tx_sel = TX_DEV_R;
          entry.last   = 1'b0;
          entry.next   = STEP_RD;
        end else begin
          entry.cmd    = WR | STO;
          entry.tx_sel = TX_WDATA;
          entry.last   = 1'b1;
          entry.next   = STEP_DEV;
        end
      end
      STEP_RD: begin
        if (is_read) begin
          entry.cmd    = RD | NACK | STO;
          entry.tx_sel = TX_NONE;
          entry.last   = 1'b1;
          entry.next   = STEP_DEV;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer in front of the I2C bit shifter. Accepts one
// register read/write, walks the step table issuing Go/Cmd/Tx_DATA per byte,
// waits for Trans_Done on each, collects ACKs and read data, and guards each
// byte step with a watchdog.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100_000,
  parameter int CNT_W       = 17
) (
  input logic           Clk,
  input logic           Rst,
  i2c_reg_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_reg;
  logic [2:0]       step_reg;
  logic             last_reg;
  logic [CNT_W-1:0] wd_cnt_reg;
  logic [CNT_W-1:0] wd_cnt_next;

  // latched request
  logic             is_read_reg;
  logic             addr_mode_reg;
  logic [6:0]       dev_reg;
  logic [15:0]      addr_reg;
  logic [7:0]       wdata_reg;

  // registered outputs
  logic [7:0]       rd_data_reg;
  logic             rw_done_reg;
  logic             ack_err_reg;
  logic             timeout_reg;
  logic             busy_reg;
  logic [5:0]       cmd_reg;
  logic             go_reg;
  logic [7:0]       tx_reg;

  logic             accept;
  logic             req_is_read;
  logic             rom_is_read;
  logic             rom_addr_mode;
  logic [6:0]       src_dev;
  logic [7:0]       tx_byte;
  step_t            rom_entry;
  logic             unused_dev_lsb;

  // Bit 0 of the device ID is always replaced by the phase R/W bit
  assign unused_dev_lsb = bus.Dev_Id[0];

  // Write wins over a simultaneous read
  assign accept      = (state_reg == ST_IDLE) && (bus.Wr_Req || bus.Rd_Req);
  assign req_is_read = bus.Rd_Req && !bus.Wr_Req;
  assign wd_cnt_next = wd_cnt_reg + CNT_W'(1);

  // In IDLE the first step is loaded straight from the live request, so the
  // table and the device byte look at the inputs rather than the latches
  assign rom_is_read   = (state_reg == ST_IDLE) ? req_is_read   : is_read_reg;
  assign rom_addr_mode = (state_reg == ST_IDLE) ? bus.Addr_Mode : addr_mode_reg;
  assign src_dev       = (state_reg == ST_IDLE) ? bus.Dev_Id[7:1] : dev_reg;

  i2c_step_rom u_step_rom (
    .is_read   (rom_is_read),
    .addr_mode (rom_addr_mode),
    .step      (step_reg),
    .entry     (rom_entry)
  );

  // Select the byte the current step puts on Tx_DATA
  always_comb begin
    tx_byte = '0;
    case (rom_entry.tx_sel)
      TX_DEV_W:   tx_byte = {src_dev, 1'b0};
      TX_ADDR_HI: tx_byte = addr_reg[15:8];
      TX_ADDR_LO: tx_byte = addr_reg[7:0];
      TX_WDATA:   tx_byte = wdata_reg;
      TX_DEV_R:   tx_byte = {dev_reg, 1'b1};
      default:    tx_byte = '0;
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= ST_IDLE;
      step_reg      <= STEP_DEV;
      last_reg      <= 1'b0;
      wd_cnt_reg    <= '0;
      is_read_reg   <= 1'b0;
      addr_mode_reg <= 1'b0;
      dev_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rd_data_reg   <= '0;
      rw_done_reg   <= 1'b0;
      ack_err_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      cmd_reg       <= '0;
      go_reg        <= 1'b0;
      tx_reg        <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            is_read_reg   <= req_is_read;
            addr_mode_reg <= bus.Addr_Mode;
            dev_reg       <= bus.Dev_Id[7:1];
            addr_reg      <= bus.Reg_Addr;
            wdata_reg     <= bus.Wr_Data;
            ack_err_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            go_reg        <= 1'b1;
            cmd_reg       <= rom_entry.cmd;
            tx_reg        <= tx_byte;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          go_reg     <= 1'b0;
          wd_cnt_reg <= '0;
          state_reg  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion beats the watchdog when both land in the same cycle
          if (bus.Trans_Done) begin
            if (|(cmd_reg & WR) && bus.ack_i) begin
              ack_err_reg <= 1'b1;
            end
            if (|(cmd_reg & RD)) begin
              rd_data_reg <= bus.Rx_DATA;
            end
            last_reg  <= rom_entry.last;
            step_reg  <= rom_entry.next;
            state_reg <= ST_NEXT;
          end else if (wd_cnt_next == WD_LAST) begin
            timeout_reg <= 1'b1;
            rw_done_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_FINISH;
          end else begin
            wd_cnt_reg <= wd_cnt_next;
          end
        end
        ST_NEXT: begin
          if (last_reg) begin
            rw_done_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_FINISH;
          end else begin
            go_reg    <= 1'b1;
            cmd_reg   <= rom_entry.cmd;
            tx_reg    <= tx_byte;
            state_reg <= ST_ISSUE;
          end
        end
        ST_FINISH: begin
          rw_done_reg <= 1'b0;
          step_reg    <= STEP_DEV;
          last_reg    <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.Rd_Data = rd_data_reg;
  assign bus.RW_Done = rw_done_reg;
  assign bus.Ack_Err = ack_err_reg;
  assign bus.Timeout = timeout_reg;
  assign bus.Busy    = busy_reg;
  assign bus.Cmd     = cmd_reg;
  assign bus.Go      = go_reg;
  assign bus.Tx_DATA = tx_reg;

endmodule
